// File: rtl/alu_writeback.sv
// ALU writeback stage: registers ALU/load results, holds the carry and zero flags, drives the RF write port.
// Optional same-cycle forwarding of the pending write is enabled by defining ALU_WB_FWD_EN.
module alu_writeback #(
   parameter int unsigned DW           = 8,
   parameter int unsigned RA           = 3,
   parameter int unsigned ZERO_REG     = 1,
   parameter int unsigned LOAD_TIMEOUT = 15
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_alu_out,
   input  logic          i_alu_sc_out,
   input  logic          i_alu_zero,
   input  logic [RA-1:0] i_dest,
   input  logic          i_wr_reg,
   input  logic          i_wr_sc,
   input  logic          i_is_load,
   input  logic [DW-1:0] i_mem_rdata,
   input  logic          i_mem_rvalid,
   output logic          o_sc_flag,
   output logic          o_zero_flag,
   output logic          o_rf_we,
   output logic [RA-1:0] o_rf_waddr,
   output logic [DW-1:0] o_rf_wdata,
   output logic          o_fwd_valid,
   output logic [RA-1:0] o_fwd_addr,
   output logic [DW-1:0] o_fwd_data,
   output logic          o_load_err
);

   typedef enum logic [1:0] {StIdle, StWrite, StLoadWait} state_e;

   localparam logic [7:0] LastCnt = 8'(LOAD_TIMEOUT - 1);

   state_e        r_state;
   state_e        w_state_next;
   logic [7:0]    r_cnt;
   logic [RA-1:0] r_ld_dest;
   logic          r_ld_wr;
   logic          r_wr_en;
   logic [RA-1:0] r_waddr;
   logic [DW-1:0] r_wdata;
   logic          r_sc;
   logic          r_zero;
   logic          r_err;

   logic w_ready;
   logic w_accept;
   logic w_alu_we;
   logic w_ld_hit;
   logic w_ld_expire;
   logic w_rf_we;

   // Effective write enable: writes to r0 are dropped when it is hardwired to zero.
   function automatic logic dest_ok(input logic [RA-1:0] d);
      return !((ZERO_REG != 0) && (d == '0));
   endfunction

   always_comb begin
      w_ready     = !i_reset && (r_state != StLoadWait);
      w_accept    = i_in_valid && w_ready;
      w_alu_we    = i_wr_reg && dest_ok(i_dest);
      w_ld_hit    = (r_state == StLoadWait) && i_mem_rvalid;
      // Data arriving on the expiry cycle wins over the timeout.
      w_ld_expire = (r_state == StLoadWait) && !i_mem_rvalid && (r_cnt == LastCnt);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle, StWrite: begin
            if (w_accept) begin
               w_state_next = i_is_load ? StLoadWait : StWrite;
            end else begin
               w_state_next = StIdle;
            end
         end
         StLoadWait: begin
            if (w_ld_hit) begin
               w_state_next = StWrite;
            end else if (w_ld_expire) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt     <= '0;
         r_ld_dest <= '0;
         r_ld_wr   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_sc      <= 1'b0;
         r_zero    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept && !i_is_load) begin
            r_zero  <= i_alu_zero;
            r_wr_en <= w_alu_we;
            if (i_wr_sc) begin
               r_sc <= i_alu_sc_out;
            end
            if (w_alu_we) begin
               r_waddr <= i_dest;
               r_wdata <= i_alu_out;
            end
         end
         if (w_accept && i_is_load) begin
            r_ld_dest <= i_dest;
            r_ld_wr   <= i_wr_reg && dest_ok(i_dest);
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
         end
         if (r_state == StLoadWait) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (w_ld_hit) begin
            r_zero  <= (i_mem_rdata == '0);
            r_wr_en <= r_ld_wr;
            if (r_ld_wr) begin
               r_waddr <= r_ld_dest;
               r_wdata <= i_mem_rdata;
            end
         end
         if (w_ld_expire) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_rf_we     = (r_state == StWrite) && r_wr_en;
      o_in_ready  = w_ready;
      o_rf_we     = w_rf_we;
      o_rf_waddr  = r_waddr;
      o_rf_wdata  = r_wdata;
      o_sc_flag   = r_sc;
      o_zero_flag = r_zero;
      o_load_err  = r_err;
   end

`ifdef ALU_WB_FWD_EN
   assign o_fwd_valid = w_rf_we;
   assign o_fwd_addr  = r_waddr;
   assign o_fwd_data  = r_wdata;
`else
   assign o_fwd_valid = 1'b0;
   assign o_fwd_addr  = '0;
   assign o_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: two instances (load timeout 15 and 4) share stimulus and are checked
// every cycle against a transaction-level reference model.
module tb_alu_writeback;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] alu_out;
   logic       alu_sc_out;
   logic       alu_zero;
   logic [2:0] dest;
   logic       wr_reg;
   logic       wr_sc;
   logic       is_load;
   logic [7:0] mem_rdata;
   logic       mem_rvalid;

   logic       o_ready [2];
   logic       o_sc    [2];
   logic       o_zero  [2];
   logic       o_we    [2];
   logic [2:0] o_waddr [2];
   logic [7:0] o_wdata [2];
   logic       o_fvalid[2];
   logic [2:0] o_faddr [2];
   logic [7:0] o_fdata [2];
   logic       o_err   [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_writeback #(.DW(8), .RA(3), .ZERO_REG(1), .LOAD_TIMEOUT(15)) u_a (
      .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(o_ready[0]),
      .i_alu_out(alu_out), .i_alu_sc_out(alu_sc_out), .i_alu_zero(alu_zero), .i_dest(dest),
      .i_wr_reg(wr_reg), .i_wr_sc(wr_sc), .i_is_load(is_load), .i_mem_rdata(mem_rdata),
      .i_mem_rvalid(mem_rvalid), .o_sc_flag(o_sc[0]), .o_zero_flag(o_zero[0]),
      .o_rf_we(o_we[0]), .o_rf_waddr(o_waddr[0]), .o_rf_wdata(o_wdata[0]),
      .o_fwd_valid(o_fvalid[0]), .o_fwd_addr(o_faddr[0]), .o_fwd_data(o_fdata[0]),
      .o_load_err(o_err[0])
   );

   alu_writeback #(.DW(8), .RA(3), .ZERO_REG(1), .LOAD_TIMEOUT(4)) u_b (
      .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(o_ready[1]),
      .i_alu_out(alu_out), .i_alu_sc_out(alu_sc_out), .i_alu_zero(alu_zero), .i_dest(dest),
      .i_wr_reg(wr_reg), .i_wr_sc(wr_sc), .i_is_load(is_load), .i_mem_rdata(mem_rdata),
      .i_mem_rvalid(mem_rvalid), .o_sc_flag(o_sc[1]), .o_zero_flag(o_zero[1]),
      .o_rf_we(o_we[1]), .o_rf_waddr(o_waddr[1]), .o_rf_wdata(o_wdata[1]),
      .o_fwd_valid(o_fvalid[1]), .o_fwd_addr(o_faddr[1]), .o_fwd_data(o_fdata[1]),
      .o_load_err(o_err[1])
   );

   // Reference model: one outstanding load per instance, tracked by elapsed wait cycles.
   int         tmo[2] = '{15, 4};
   bit         m_wait  [2];
   int         m_cnt   [2];
   logic [2:0] m_ldst  [2];
   bit         m_ldwr  [2];
   bit         m_we    [2];
   logic [2:0] m_waddr [2];
   logic [7:0] m_wdata [2];
   bit         m_sc    [2];
   bit         m_zero  [2];
   bit         m_err   [2];

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         m_wait[i] = 0; m_cnt[i] = 0; m_ldst[i] = '0; m_ldwr[i] = 0; m_we[i] = 0;
         m_waddr[i] = '0; m_wdata[i] = '0; m_sc[i] = 0; m_zero[i] = 0; m_err[i] = 0;
      end
   endtask

   task automatic m_step();
      for (int i = 0; i < 2; i++) begin
         bit nwe = 0;
         if (m_wait[i]) begin
            m_cnt[i]++;
            if (mem_rvalid) begin
               m_zero[i] = (mem_rdata == 8'h00);
               if (m_ldwr[i]) begin
                  nwe = 1; m_waddr[i] = m_ldst[i]; m_wdata[i] = mem_rdata;
               end
               m_wait[i] = 0;
            end else if (m_cnt[i] == tmo[i]) begin
               m_err[i]  = 1;
               m_wait[i] = 0;
            end
         end else if (in_valid) begin
            if (is_load) begin
               m_wait[i] = 1; m_cnt[i] = 0; m_ldst[i] = dest;
               m_ldwr[i] = wr_reg && (dest != 3'd0);
            end else begin
               m_zero[i] = alu_zero;
               if (wr_sc) m_sc[i] = alu_sc_out;
               if (wr_reg && dest != 3'd0) begin
                  nwe = 1; m_waddr[i] = dest; m_wdata[i] = alu_out;
               end
            end
         end
         m_we[i] = nwe;
      end
   endtask

   task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, inst, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk("in_ready", i, 32'(o_ready[i]), 32'(!rst && !m_wait[i]));
         chk("rf_we", i, 32'(o_we[i]), 32'(m_we[i]));
         chk("rf_waddr", i, 32'(o_waddr[i]), 32'(m_waddr[i]));
         chk("rf_wdata", i, 32'(o_wdata[i]), 32'(m_wdata[i]));
         chk("sc_flag", i, 32'(o_sc[i]), 32'(m_sc[i]));
         chk("zero_flag", i, 32'(o_zero[i]), 32'(m_zero[i]));
         chk("load_err", i, 32'(o_err[i]), 32'(m_err[i]));
`ifdef ALU_WB_FWD_EN
         chk("fwd_valid", i, 32'(o_fvalid[i]), 32'(m_we[i]));
         chk("fwd_addr", i, 32'(o_faddr[i]), 32'(m_waddr[i]));
         chk("fwd_data", i, 32'(o_fdata[i]), 32'(m_wdata[i]));
`else
         chk("fwd_valid", i, 32'(o_fvalid[i]), 32'd0);
         chk("fwd_addr", i, 32'(o_faddr[i]), 32'd0);
         chk("fwd_data", i, 32'(o_fdata[i]), 32'd0);
`endif
      end
   endtask

   // Inputs are sampled at the coming edge; outputs are checked 1 time unit after it.
   task automatic step();
      m_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic set_in(input bit v, input logic [7:0] a, input bit sc, input bit z,
                         input logic [2:0] d, input bit wr, input bit ws, input bit ld);
      in_valid = v; alu_out = a; alu_sc_out = sc; alu_zero = z;
      dest = d; wr_reg = wr; wr_sc = ws; is_load = ld;
   endtask

   task automatic set_mem(input bit v, input logic [7:0] d);
      mem_rvalid = v; mem_rdata = d;
   endtask

   task automatic idle();
      set_in(0, 8'h00, 0, 0, 3'd0, 0, 0, 0);
      set_mem(0, 8'h00);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      rst = 1'b1;
      m_reset();
      #2;
      check_all();
      rst = 1'b0;
      #1;
      check_all();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      m_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      #1;
      chk("ready_after_release", 0, 32'(o_ready[0]), 32'd1);
      check_all();

      // Back-to-back ALU writes.
      set_in(1, 8'h5A, 0, 0, 3'd3, 1, 0, 0);
      step();
      chk("b2b_first_addr", 0, 32'(o_waddr[0]), 32'd3);
      chk("b2b_first_data", 0, 32'(o_wdata[0]), 32'h5A);
      set_in(1, 8'h00, 0, 1, 3'd4, 1, 0, 0);
      step();
      chk("b2b_second_we", 0, 32'(o_we[0]), 32'd1);
      chk("b2b_second_zero", 0, 32'(o_zero[0]), 32'd1);
      idle();
      step();
      chk("b2b_we_drop", 0, 32'(o_we[0]), 32'd0);

      pulse_reset();

      // Carry gating.
      set_in(1, 8'h11, 1, 0, 3'd1, 1, 1, 0);
      step();
      set_in(1, 8'h22, 0, 0, 3'd1, 1, 0, 0);
      step();
      idle();
      step();
      chk("carry_held", 0, 32'(o_sc[0]), 32'd1);

      // Zero-register suppression: flag updates, no write.
      set_in(1, 8'h00, 0, 1, 3'd5, 1, 0, 0);
      step();
      set_in(1, 8'hFF, 0, 0, 3'd0, 1, 0, 0);
      step();
      chk("r0_we", 0, 32'(o_we[0]), 32'd0);
      chk("r0_zero", 0, 32'(o_zero[0]), 32'd0);
      idle();
      step();

      // Load with 5-cycle wait (instance b times out on the same traffic).
      set_in(1, 8'h00, 0, 0, 3'd2, 1, 0, 1);
      step();
      idle();
      for (int k = 0; k < 4; k++) begin
         step();
         chk("load_wait_ready", 0, 32'(o_ready[0]), 32'd0);
      end
      set_mem(1, 8'h00);
      step();
      chk("load_we", 0, 32'(o_we[0]), 32'd1);
      chk("load_addr", 0, 32'(o_waddr[0]), 32'd2);
      chk("load_sc_kept", 0, 32'(o_sc[0]), 32'd1);
      set_mem(0, 8'h00);
      step();

      pulse_reset();

      // Expiry-cycle data wins on the timeout-4 instance.
      set_in(1, 8'h00, 0, 0, 3'd6, 1, 0, 1);
      step();
      idle();
      for (int k = 0; k < 3; k++) step();
      set_mem(1, 8'h3C);
      step();
      chk("expiry_we", 1, 32'(o_we[1]), 32'd1);
      chk("expiry_err", 1, 32'(o_err[1]), 32'd0);
      set_mem(0, 8'h00);
      step();

      // Timeout with no data; the late pulse is ignored.
      set_in(1, 8'h00, 0, 0, 3'd7, 1, 0, 1);
      step();
      idle();
      for (int k = 0; k < 4; k++) step();
      chk("timeout_err", 1, 32'(o_err[1]), 32'd1);
      chk("timeout_ready", 1, 32'(o_ready[1]), 32'd1);
      for (int k = 0; k < 12; k++) step();
      set_mem(1, 8'h99);
      step();
      chk("late_rvalid_we", 1, 32'(o_we[1]), 32'd0);
      set_mem(0, 8'h00);
      step();

      // Reset mid-load abandons it; a late data pulse has no effect.
      pulse_reset();
      set_in(1, 8'h00, 0, 0, 3'd3, 1, 0, 1);
      step();
      idle();
      step();
      pulse_reset();
      set_mem(1, 8'h44);
      step();
      chk("post_reset_rvalid", 0, 32'(o_we[0]), 32'd0);
      set_mem(0, 8'h00);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         set_in($urandom_range(0, 9) < 6, 8'($urandom), 1'($urandom), 1'($urandom),
                3'($urandom), $urandom_range(0, 9) < 8, 1'($urandom),
                $urandom_range(0, 9) < 3);
         set_mem($urandom_range(0, 9) < 2, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream neighbour of the 8-bit combinational ALU. Registers the ALU result, carry/shift-out and zero flag, then drives the register-file write port.
- Holds the architectural carry flag that feeds back to the ALU's SC_IN.
- Sequences load results from data memory with a bounded wait, and optionally forwards the pending write to operand select.

Parameters:
- DW, 8, datapath width. Matches the ALU OUT width.
- RA, 3, register-file address width.
- ZERO_REG, 1, when 1, writes to address 0 are suppressed (RF_WE held low).
- LOAD_TIMEOUT, 15, maximum cycles spent waiting for MEM_RVALID. Legal range 1..255.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  execute stage presents an instruction.
- IN_READY  out  1  stage can accept this cycle.
- ALU_OUT  in  DW  ALU result.
- ALU_SC_OUT  in  1  ALU shift/carry out.
- ALU_ZERO  in  1  ALU zero flag.
- DEST  in  RA  destination register.
- WR_REG  in  1  instruction writes DEST.
- WR_SC  in  1  instruction updates the carry flag.
- IS_LOAD  in  1  result comes from memory, not the ALU.
- MEM_RDATA  in  DW  load data.
- MEM_RVALID  in  1  load data valid, one-cycle pulse.
- SC_FLAG  out  1  architectural carry. Drives ALU SC_IN.
- ZERO_FLAG  out  1  last-result zero flag.
- RF_WE  out  1  register-file write enable.
- RF_WADDR  out  RA  write address.
- RF_WDATA  out  DW  write data.
- FWD_VALID  out  1  pending write visible for forwarding.
- FWD_ADDR  out  RA  forwarding address.
- FWD_DATA  out  DW  forwarding data.
- LOAD_ERR  out  1  sticky load-timeout error.

Behaviour:
- Reset: all outputs and state registers go to 0, state = IDLE. IN_READY is 0 while RESET is high and 1 in the first cycle after release.
- Accept condition: IN_VALID && IN_READY at a rising edge. IN_READY = (state != LOAD_WAIT).
- States:
  - IDLE: no write pending.
  - WRITE: one registered result is driven this cycle.
  - LOAD_WAIT: waiting for memory data.
- Non-load accept (IS_LOAD=0):
  - Capture ALU_OUT and DEST; go to WRITE.
  - In the next cycle, RF_WE = WR_REG && !(ZERO_REG && DEST==0), driving the captured address and data. Latency is exactly 1 cycle.
  - From WRITE, a new accept goes back to WRITE, so throughput is 1 per cycle. Otherwise the state returns to IDLE.
- Flags on non-load accept:
  - ZERO_FLAG <= ALU_ZERO.
  - SC_FLAG <= ALU_SC_OUT only if WR_SC; otherwise SC_FLAG holds.
  - New flag values are visible the cycle after accept.
- Load accept (IS_LOAD=1):
  - Capture DEST, clear the wait counter, go to LOAD_WAIT. IN_READY is 0 for the whole wait.
  - The counter increments each cycle in LOAD_WAIT.
  - On MEM_RVALID: capture MEM_RDATA, set ZERO_FLAG <= (MEM_RDATA==0), go to WRITE. RF_WE follows in the next cycle. SC_FLAG is never changed by a load.
  - If the counter reaches LOAD_TIMEOUT with no MEM_RVALID: set LOAD_ERR, no register write, go to IDLE, flags unchanged.
  - MEM_RVALID in the same cycle as expiry: the data wins and LOAD_ERR is not set.
- MEM_RVALID outside LOAD_WAIT is ignored.
- LOAD_ERR stays set until RESET.
- Reset mid-load abandons the load. A late MEM_RVALID after reset has no effect.
- Counter width is 8 bits and never wraps: it is cleared on entry to LOAD_WAIT.
- RF_WE is never high for more than one cycle per accepted instruction.
- RF_WADDR and RF_WDATA hold their last values when RF_WE is low.

Optional Feature:
- ALU_WB_FWD_EN defined:
  - FWD_VALID = RF_WE.
  - FWD_ADDR = RF_WADDR and FWD_DATA = RF_WDATA, combinationally in the same cycle, so the upstream operand mux can bypass the register file.
- Not defined: FWD_VALID, FWD_ADDR and FWD_DATA are tied to 0, and the decoder must stall on hazards.

Test Plan:
- Reset check: RESET pulsed mid-cycle with no clock edge -> all outputs 0 immediately. IN_READY=1 on the first cycle after release.
- Back-to-back writes:
  - Stimulus: accept ALU_OUT=0x5A, DEST=3, WR_REG=1, then ALU_OUT=0x00, ALU_ZERO=1, DEST=4 on the next cycle.
  - Response: RF_WE high two consecutive cycles with (3,0x5A) then (4,0x00). ZERO_FLAG=1 after the second.
- Carry gating:
  - Stimulus: accept with ALU_SC_OUT=1, WR_SC=1; then accept with ALU_SC_OUT=0, WR_SC=0.
  - Response: SC_FLAG goes to 1 and stays 1.
- Zero-register suppression: DEST=0, WR_REG=1, ZERO_REG=1, ALU_OUT=0xFF -> RF_WE stays 0. ZERO_FLAG still updates.
- Load with wait:
  - Stimulus: load to DEST=2, MEM_RVALID with MEM_RDATA=0x00 after 5 cycles.
  - Response: IN_READY low for those 5 cycles. RF_WE next cycle with (2,0x00). ZERO_FLAG=1, SC_FLAG unchanged.
- Load timeout, LOAD_TIMEOUT=4:
  - Case A, no MEM_RVALID -> LOAD_ERR=1, no RF_WE, return to IDLE. A later MEM_RVALID pulse is ignored.
  - Case B, MEM_RVALID on the expiry cycle -> write occurs, LOAD_ERR=0.
  - With ALU_WB_FWD_EN defined, FWD_VALID mirrors RF_WE in every scenario above.
